leaf_out_arbiter: RTL and testbench

Parametrised output stage for a leaf, sitting between a leaf's user kernel and the BFT. It accepts NUM_OUT_PORTS user output streams on vld/ack handshakes and arbitrates among them round-robin. Each winning word is packetised with a per-port destination (leaf, port, BRAM write address) that is loaded at runtime by config packets. Per-port credit counters, replenished by freespace-update packets from the BFT, gate every send so a destination BRAM never overflows.

---
 rtl/leaf_out_arbiter.sv | 156 +++++++++++++++
 tb/tb_leaf_out_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/leaf_out_arbiter.sv
// Leaf output stage: round-robin arbitration of user streams into BFT packets, gated by per-port credits.
// Optional build macro LEAF_OUT_RESEND_EN: resend blocks grants and blanks dout while high.
module leaf_out_arbiter #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_OUT_PORTS         = 1,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [PACKET_BITS-1:0]                  din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
    input  logic                                    resend,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user
);

    localparam int CRED_W       = NUM_BRAM_ADDR_BITS + 1;
    localparam int CRED_MAX     = 1 << NUM_BRAM_ADDR_BITS;
    localparam int ADDR_LSB     = PAYLOAD_BITS;
    localparam int PORT_LSB     = PAYLOAD_BITS + NUM_ADDR_BITS;
    localparam int LEAF_LSB     = PORT_LSB + NUM_PORT_BITS;
    localparam int CFG_PORT_LSB = NUM_PORT_BITS;
    localparam int CFG_LEAF_LSB = 2 * NUM_PORT_BITS;
    localparam int CFG_TOP      = CFG_LEAF_LSB + NUM_LEAF_BITS;

    function automatic logic [CRED_W-1:0] sat_credit(input int value);
        if (value > CRED_MAX) return CRED_W'(CRED_MAX);
        return CRED_W'(value);
    endfunction

    function automatic logic [NUM_ADDR_BITS-1:0] fit_addr(input logic [NUM_BRAM_ADDR_BITS-1:0] w);
        return NUM_ADDR_BITS'(w);
    endfunction

    logic [NUM_LEAF_BITS-1:0]      leaf_tab [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0]      port_tab [NUM_OUT_PORTS];
    logic [CRED_W-1:0]             credit   [NUM_OUT_PORTS];
    logic [NUM_BRAM_ADDR_BITS-1:0] waddr    [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0]      cfg_vld;
    logic [NUM_PORT_BITS-1:0]      rr_ptr;

    logic                          pkt_vld, is_cfg, is_cred;
    logic [NUM_PORT_BITS-1:0]      pkt_port, pkt_k, cfg_port;
    logic [NUM_LEAF_BITS-1:0]      cfg_leaf;
    logic [PAYLOAD_BITS-1:0]       pkt_payload;
    logic                          send_ok;
    logic                          unused_bits;

    assign pkt_vld     = din_leaf_bft2interface[PACKET_BITS-1];
    assign pkt_port    = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
    assign pkt_payload = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
    assign pkt_k       = pkt_payload[NUM_PORT_BITS-1:0];
    assign cfg_port    = pkt_payload[CFG_PORT_LSB +: NUM_PORT_BITS];
    assign cfg_leaf    = pkt_payload[CFG_LEAF_LSB +: NUM_LEAF_BITS];
    assign is_cfg      = pkt_vld && (pkt_port == '0);
    assign is_cred     = pkt_vld && (pkt_port == NUM_PORT_BITS'(1));
    assign unused_bits = ^{resend, din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS],
                           din_leaf_bft2interface[ADDR_LSB +: NUM_ADDR_BITS],
                           pkt_payload[PAYLOAD_BITS-1:CFG_TOP]};

`ifdef LEAF_OUT_RESEND_EN
    assign send_ok = ~resend;
`else
    assign send_ok = 1'b1;
`endif

    // Stage p0: eligibility, round-robin pick and packet assembly
    logic [NUM_OUT_PORTS-1:0] elig, gnt;
    logic                     found_hi, found_lo, grant_vld;
    logic [NUM_PORT_BITS-1:0] hi_idx, lo_idx, grant_idx;
    logic [PACKET_BITS-1:0]   pkt_p0, pkt_p1;

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++)
            elig[i] = vld_user2interface[i] & cfg_vld[i] & (credit[i] != '0) & send_ok;
    end

    // Prefer the lowest eligible port at or above rr_ptr, otherwise wrap to the lowest overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (elig[i] && !found_lo) begin
                found_lo = 1'b1;
                lo_idx   = NUM_PORT_BITS'(i);
            end
            if (elig[i] && !found_hi && (NUM_PORT_BITS'(i) >= rr_ptr)) begin
                found_hi = 1'b1;
                hi_idx   = NUM_PORT_BITS'(i);
            end
        end
        grant_vld = found_lo;
        grant_idx = found_hi ? hi_idx : lo_idx;
    end

    always_comb begin
        pkt_p0 = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            gnt[i] = grant_vld && (grant_idx == NUM_PORT_BITS'(i));
            if (gnt[i])
                pkt_p0 = {1'b1, leaf_tab[i], port_tab[i], fit_addr(waddr[i]),
                          din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
        end
    end

    assign ack_interface2user = reset ? '0 : gnt;

    // Stage p1: registered packet and per-port bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_p1  <= '0;
            rr_ptr  <= '0;
            cfg_vld <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                leaf_tab[i] <= '0;
                port_tab[i] <= '0;
                credit[i]   <= '0;
                waddr[i]    <= '0;
            end
        end else begin
            pkt_p1 <= pkt_p0;
            if (grant_vld)
                rr_ptr <= (int'(grant_idx) == NUM_OUT_PORTS - 1) ? '0 : grant_idx + NUM_PORT_BITS'(1);
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (is_cfg && (pkt_k == NUM_PORT_BITS'(i))) begin
                    leaf_tab[i] <= cfg_leaf;
                    port_tab[i] <= cfg_port;
                    cfg_vld[i]  <= 1'b1;
                    credit[i]   <= CRED_W'(CRED_MAX);
                    waddr[i]    <= '0;
                end else begin
                    credit[i] <= sat_credit(int'(credit[i])
                                 + ((is_cred && (pkt_k == NUM_PORT_BITS'(i))) ? FREESPACE_UPDATE_SIZE : 0)
                                 - (gnt[i] ? 1 : 0));
                    if (gnt[i])
                        waddr[i] <= waddr[i] + NUM_BRAM_ADDR_BITS'(1);
                end
            end
        end
    end

`ifdef LEAF_OUT_RESEND_EN
    assign dout_leaf_interface2bft = resend ? '0 : pkt_p1;
`else
    assign dout_leaf_interface2bft = pkt_p1;
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Bench for leaf_out_arbiter with three output ports: directed scenarios plus random traffic against a reference model.
module tb_leaf_out_arbiter;
    localparam int N = 3;
`ifdef LEAF_OUT_RESEND_EN
    localparam bit RS_EN = 1'b1;
`else
    localparam bit RS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [48:0]   din_bft;
    logic [48:0]   dout;
    logic          resend;
    logic [95:0]   din_user;
    logic [2:0]    vld;
    logic [2:0]    ack;

    always #5 clk = ~clk;

    leaf_out_arbiter #(.NUM_OUT_PORTS(N)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_bft2interface  (din_bft),
        .dout_leaf_interface2bft (dout),
        .resend                  (resend),
        .din_leaf_user2interface (din_user),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int m_leaf[N], m_port[N], m_credit[N], m_waddr[N];
    bit m_cfg[N];
    int m_rr;
    int last_gnt;
    int cnt;
    int rr_exp[6] = '{1, 2, 0, 1, 2, 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_leaf[i] = 0; m_port[i] = 0; m_credit[i] = 0; m_waddr[i] = 0; m_cfg[i] = 1'b0;
        end
        m_rr = 0;
    endtask

    function automatic logic [48:0] cfg_pkt(input int k, input int leaf, input int port);
        logic [31:0] p;
        p = $urandom;
        p[12:0] = {5'(leaf), 4'(port), 4'(k)};
        return {1'b1, 5'($urandom), 4'd0, 7'($urandom), p};
    endfunction

    function automatic logic [48:0] cred_pkt(input int k);
        logic [31:0] p;
        p = $urandom;
        p[3:0] = 4'(k);
        return {1'b1, 5'($urandom), 4'd1, 7'($urandom), p};
    endfunction

    // One clock of stimulus; checks ack in-cycle and dout after the edge.
    task automatic run_cycle(input logic [2:0] v, input logic [48:0] pkt, input logic rs, input logic [31:0] d0);
        logic [31:0] d[N];
        logic [2:0]  exp_ack;
        logic [48:0] exp_pkt;
        int g, pf, k, i;
        d[0] = d0; d[1] = $urandom; d[2] = $urandom;
        vld = v; din_bft = pkt; resend = rs; din_user = {d[2], d[1], d[0]};
        #2;
`ifdef LEAF_OUT_RESEND_EN
        if (rs) check("dout_resend", dout, 49'd0);
`endif
        g = -1;
        for (int j = 0; j < N; j++) begin
            i = (m_rr + j) % N;
            if (g < 0 && v[i] && m_cfg[i] && m_credit[i] > 0 && !(RS_EN && rs)) g = i;
        end
        exp_ack = (g < 0) ? 3'b000 : 3'(1 << g);
        check("ack", ack, exp_ack);
        exp_pkt = (g < 0) ? 49'd0 : {1'b1, 5'(m_leaf[g]), 4'(m_port[g]), 7'(m_waddr[g]), d[g]};
        if (g >= 0) begin
            m_credit[g] = m_credit[g] - 1;
            m_waddr[g]  = (m_waddr[g] + 1) % 128;
            m_rr        = (g + 1) % N;
        end
        pf = int'(pkt[42:39]);
        k  = int'(pkt[3:0]);
        if (pkt[48] && k < N) begin
            if (pf == 0) begin
                m_leaf[k] = int'(pkt[12:8]); m_port[k] = int'(pkt[7:4]);
                m_credit[k] = 128; m_waddr[k] = 0; m_cfg[k] = 1'b1;
            end else if (pf == 1) begin
                m_credit[k] = (m_credit[k] + 64 > 128) ? 128 : m_credit[k] + 64;
            end
        end
        last_gnt = g;
        @(posedge clk); #1;
        check("dout", dout, exp_pkt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; din_bft = '0; resend = 1'b0; din_user = '0; vld = 3'b111;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", dout, 49'd0);
        check("rst_ack", ack, 3'b000);
        reset = 1'b0;

        // First configured word
        run_cycle(3'b000, cfg_pkt(0, 3, 2), 1'b0, $urandom);
        run_cycle(3'b001, 49'd0, 1'b0, 32'hDEADBEEF);
        check("deadbeef", dout, {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF});

        // Round robin over three ports
        run_cycle(3'b000, cfg_pkt(1, $urandom_range(0, 31), $urandom_range(0, 15)), 1'b0, $urandom);
        run_cycle(3'b000, cfg_pkt(2, $urandom_range(0, 31), $urandom_range(0, 15)), 1'b0, $urandom);
        for (int c = 0; c < 6; c++) begin
            run_cycle(3'b111, 49'd0, 1'b0, $urandom);
            check("rr_order", last_gnt, rr_exp[c]);
        end

        // Credit exhaustion and one replenish
        run_cycle(3'b000, cfg_pkt(0, $urandom_range(0, 31), $urandom_range(0, 15)), 1'b0, $urandom);
        cnt = 0;
        for (int c = 0; c < 135; c++) begin
            run_cycle(3'b001, 49'd0, 1'b0, $urandom);
            if (last_gnt == 0) cnt++;
        end
        check("cred_exhaust", cnt, 128);
        run_cycle(3'b000, cred_pkt(0), 1'b0, $urandom);
        cnt = 0;
        for (int c = 0; c < 70; c++) begin
            run_cycle(3'b001, 49'd0, 1'b0, $urandom);
            if (last_gnt == 0) cnt++;
        end
        check("cred_refill", cnt, 64);

        // Credit packet and grant together at credit 5
        run_cycle(3'b000, cfg_pkt(1, $urandom_range(0, 31), $urandom_range(0, 15)), 1'b0, $urandom);
        for (int c = 0; c < 123; c++) run_cycle(3'b010, 49'd0, 1'b0, $urandom);
        run_cycle(3'b010, cred_pkt(1), 1'b0, $urandom);
        check("cred_net_gnt", last_gnt, 1);
        cnt = 0;
        for (int c = 0; c < 75; c++) begin
            run_cycle(3'b010, 49'd0, 1'b0, $urandom);
            if (last_gnt == 1) cnt++;
        end
        check("cred_net", cnt, 68);

        // Write address wrap
        run_cycle(3'b000, cfg_pkt(2, $urandom_range(0, 31), $urandom_range(0, 15)), 1'b0, $urandom);
        cnt = 0;
        for (int c = 0; c < 130; c++) begin
            run_cycle(3'b100, (c % 32 == 0) ? cred_pkt(2) : 49'd0, 1'b0, $urandom);
            if (last_gnt == 2) begin
                cnt++;
                if (cnt == 128) check("waddr_top", dout[38:32], 7'd127);
                if (cnt == 129) check("waddr_wrap", dout[38:32], 7'd0);
            end
        end
        check("wrap_cnt", cnt, 130);

        // Resend window then resume
        for (int c = 0; c < 4; c++) run_cycle(3'b111, 49'd0, 1'b1, $urandom);
        for (int c = 0; c < 3; c++) run_cycle(3'b111, 49'd0, 1'b0, $urandom);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            logic [48:0] p;
            case ($urandom_range(0, 4))
                0: p = 49'd0;
                1: p = cfg_pkt($urandom_range(0, 4), $urandom_range(0, 31), $urandom_range(0, 15));
                2: p = cred_pkt($urandom_range(0, 4));
                3: p = {1'b1, 5'($urandom), 4'($urandom_range(2, 15)), 7'($urandom), 32'($urandom)};
                default: begin
                    p = cfg_pkt($urandom_range(0, 2), $urandom_range(0, 31), $urandom_range(0, 15));
                    p[48] = 1'b0;
                end
            endcase
            run_cycle(3'($urandom), p, ($urandom_range(0, 7) == 0), $urandom);
        end

        // Asynchronous reset while a packet is on dout
        run_cycle(3'b000, cfg_pkt(0, 5, 7), 1'b0, $urandom);
        run_cycle(3'b001, 49'd0, 1'b0, 32'h12345678);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_dout", dout, 49'd0);
        check("rst_async_ack", ack, 3'b000);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        run_cycle(3'b111, 49'd0, 1'b0, $urandom);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
